triad_seq: RTL and testbench
============================

TRIAD_SEQ -- requirements
Module: triad_seq

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 8, the maximum cycles to wait for decoded output after a triad is sent.
REQ-002 The module SHALL have port clock, input, 1, the single system clock.
REQ-003 The module SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1, a pulse that begins a test run.
REQ-005 The module SHALL have port num_triads, input, 8, the number of triads to send per run.
REQ-006 The module SHALL have port persist, input, 4, the decoder persistence setting.
REQ-007 The module SHALL have port h_strip, input, 4, the decoder one-hot half-strip output.
REQ-008 The module SHALL have port triad_skip, input, 1, the decoder's skipped-triad flag.
REQ-009 The module SHALL have port triad, output, 1, the serial triad stream driven to the decoder.
REQ-010 The module SHALL have port dec_reset, output, 1, the decoder reset.
REQ-011 The module SHALL have port persist_o, output, 4, the latched persist value driven to the decoder.
REQ-012 The module SHALL have port busy, output, 1, high while a run is in progress.
REQ-013 The module SHALL have port done, output, 1, a 1-cycle end-of-run pulse.
REQ-014 The module SHALL have ports pass_cnt, fail_cnt and skip_cnt, each output, 8, holding the per-run result counters.

Function
REQ-015 The FSM SHALL have states IDLE, RST, SEND, WAIT, HOLD, GAP and DONE; all outputs SHALL be registered.
REQ-016 In IDLE, start SHALL do the following:
- latch num_triads and persist (persist_o reflects the latched value);
- clear all counters and the triad index k;
- enter RST.
REQ-017 start SHALL be ignored in every state except IDLE.
REQ-018 In RST, dec_reset SHALL be high for exactly 2 cycles; the FSM then SHALL enter SEND, or DONE if the latched num_triads is 0.
REQ-019 SEND SHALL drive triad on 3 consecutive cycles as follows:
- 1 (start bit);
- k[1] (strip bit);
- k[0] (half-strip bit).
REQ-019a After SEND the FSM SHALL enter WAIT; triad SHALL be 0 in every other state.
REQ-020 The expected output SHALL be exp = one-hot of index {k[1],k[0]}, so k=2 gives 4'b0100.
REQ-021 In WAIT, the FSM SHALL behave as follows:
- h_strip==exp: enter HOLD with hold count 1;
- h_strip nonzero and !=exp: increment fail_cnt and enter GAP;
- TIMEOUT cycles without nonzero h_strip: increment fail_cnt and enter GAP.
REQ-022 In HOLD, each cycle with h_strip==exp SHALL increment the hold count.
REQ-023 In HOLD, when h_strip returns to 0, the FSM SHALL increment pass_cnt if the hold count equals persist+1 (fail_cnt otherwise) and enter GAP.
REQ-024 In HOLD, h_strip nonzero and !=exp, or a hold count exceeding persist+1, SHALL increment fail_cnt and enter GAP.
REQ-025 GAP SHALL last persist+2 cycles with triad 0, then increment k (8-bit, wraps) and enter SEND if k < latched num_triads, else DONE.
REQ-026 Every cycle with busy high and triad_skip high SHALL increment skip_cnt.
REQ-027 All counters SHALL saturate at 255.
REQ-028 DONE SHALL pulse done for 1 cycle and then return to IDLE.
REQ-029 Counters SHALL hold their values in IDLE until the next accepted start.
REQ-030 busy SHALL be high in every state except IDLE.
REQ-031 For persist=0, pass SHALL require exactly 1 matching cycle and GAP SHALL be 2 cycles.

Reset
REQ-032 Synchronous reset SHALL do the following:
- force IDLE;
- set triad=0, busy=0 and done=0;
- clear all counters and k;
- set persist_o=0;
- set dec_reset=1 for the reset cycle only.
REQ-033 Reset asserted mid-run SHALL abort the run with no done pulse, and the next start SHALL behave as from power-up.

Verification
REQ-034 Ideal decoder model, persist=4, num_triads=4, start -> triad shows 1,0,0 / 1,0,1 / 1,1,0 / 1,1,1, pass_cnt=4, fail_cnt=0, one done pulse.
REQ-035 Decoder model holds h_strip 3 cycles with persist=4 -> each triad fails; fail_cnt=num_triads and pass_cnt=0.
REQ-036 h_strip tied to 0, TIMEOUT=8, num_triads=2 -> each WAIT lasts 8 cycles and fail_cnt=2.
REQ-037 num_triads=0 -> dec_reset high 2 cycles, then done pulses with all counters 0.
REQ-038 triad_skip forced high for 300 cycles during a run -> skip_cnt=255 (saturated).
REQ-039 reset pulsed during HOLD -> triad=0, busy=0, counters 0, no done pulse; a following start runs normally.

Source files
------------

// File: rtl/triad_seq.sv
// Triad test sequencer: resets a half-strip decoder, streams num_triads 3-bit triads
// into it and scores each one-hot response as pass, fail or timeout.
module triad_seq #(
  parameter int TIMEOUT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_triads,
  input  logic [3:0] persist,
  input  logic [3:0] h_strip,
  input  logic       triad_skip,
  output logic       triad,
  output logic       dec_reset,
  output logic [3:0] persist_o,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic [7:0] skip_cnt
);

  typedef enum logic [2:0] {IDLE, RST, SEND, WAIT, HOLD, GAP, DONE} state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       hold, hold_n;
  logic [7:0]       k, k_n, k_inc;
  logic [7:0]       num_q, num_n;
  logic [3:0]       persist_n;
  logic [7:0]       pass_n, fail_n, skip_n;
  logic             triad_n, dec_reset_n, busy_n, done_n;
  logic [3:0]       exp_hs;
  logic [4:0]       hold_max;
  logic [CNT_W-1:0] gap_last;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign exp_hs   = 4'b0001 << k[1:0];
  assign hold_max = {1'b0, persist_o} + 5'd1;
  assign gap_last = {12'd0, persist_o} + 16'd1;
  assign k_inc    = k + 8'd1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hold_n    = hold;
    k_n       = k;
    num_n     = num_q;
    persist_n = persist_o;
    pass_n    = pass_cnt;
    fail_n    = fail_cnt;
    skip_n    = (busy && triad_skip) ? sat_inc(skip_cnt) : skip_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          state_n   = RST;
          cnt_n     = '0;
          hold_n    = '0;
          k_n       = '0;
          num_n     = num_triads;
          persist_n = persist;
          pass_n    = '0;
          fail_n    = '0;
          skip_n    = '0;
        end
      end
      RST: begin
        if (cnt == '0) begin
          cnt_n = 16'd1;
        end else begin
          cnt_n   = '0;
          state_n = (num_q == 8'd0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (cnt == 16'd2) begin
          cnt_n   = '0;
          state_n = WAIT;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      WAIT: begin
        if (h_strip == exp_hs) begin
          hold_n  = 5'd1;
          cnt_n   = '0;
          state_n = HOLD;
        end else if (h_strip != 4'd0 || cnt == WAIT_LAST) begin
          fail_n  = sat_inc(fail_cnt);
          cnt_n   = '0;
          state_n = GAP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      HOLD: begin
        // A match beyond persist+1 cycles means the decoder held too long.
        if (h_strip == 4'd0) begin
          if (hold == hold_max) pass_n = sat_inc(pass_cnt);
          else                  fail_n = sat_inc(fail_cnt);
          state_n = GAP;
        end else if (h_strip == exp_hs && hold != hold_max) begin
          hold_n = hold + 5'd1;
        end else begin
          fail_n  = sat_inc(fail_cnt);
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt == gap_last) begin
          cnt_n   = '0;
          k_n     = k_inc;
          state_n = (k_inc < num_q) ? SEND : DONE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are precomputed from the next state so they register in step with it.
    triad_n = 1'b0;
    if (state_n == SEND) begin
      if (cnt_n == '0)        triad_n = 1'b1;
      else if (cnt_n == 16'd1) triad_n = k_n[1];
      else                    triad_n = k_n[0];
    end
    dec_reset_n = (state_n == RST);
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hold      <= '0;
      k         <= '0;
      num_q     <= '0;
      persist_o <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      skip_cnt  <= '0;
      triad     <= 1'b0;
      dec_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      k         <= k_n;
      num_q     <= num_n;
      persist_o <= persist_n;
      pass_cnt  <= pass_n;
      fail_cnt  <= fail_n;
      skip_cnt  <= skip_n;
      triad     <= triad_n;
      dec_reset <= dec_reset_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_triad_seq.sv
// Bench for triad_seq: behavioural decoder model, table of runs, and a scoreboard
// of per-run results and triad bit patterns checked as the DUT produces them.
module tb_triad_seq;

  localparam int M_IDEAL  = 0;
  localparam int M_SHORT  = 1;
  localparam int M_SILENT = 2;
  localparam int M_WRONG  = 3;
  localparam int M_LONG   = 4;

  logic       clock, reset, start, triad_skip;
  logic [7:0] num_triads;
  logic [3:0] persist, h_strip;
  logic       triad, dec_reset, busy, done;
  logic [3:0] persist_o;
  logic [7:0] pass_cnt, fail_cnt, skip_cnt;

  triad_seq #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .start(start), .num_triads(num_triads),
    .persist(persist), .h_strip(h_strip), .triad_skip(triad_skip),
    .triad(triad), .dec_reset(dec_reset), .persist_o(persist_o), .busy(busy),
    .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt)
  );

  typedef struct {
    int num; int p; int mode; int e_pass; int e_fail; int e_busy;
  } row_t;
  typedef struct {
    int e_pass; int e_fail; int e_skip; int e_busy;
  } exp_t;

  row_t rows[9];
  exp_t sb[$];
  int   tq[$];

  int total = 0;
  int bad = 0;
  int done_pulses = 0;
  int bsy_cnt = 0;
  int dr_cnt = 0;
  int dmode = M_IDEAL;
  int dp = 0;

  // decoder model state
  int       dph = 0, dhc = 0, dhl = 0;
  logic     db1 = 1'b0;
  logic [1:0] didx = 2'd0, dwrong = 2'd0;
  // monitor state
  int       tph = 0;
  logic     tb1 = 1'b0;
  int       te = 0;
  exp_t     er;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Ideal-ish decoder: decodes the triad, then drives h_strip for a mode-dependent length.
  initial begin
    h_strip = 4'd0;
    forever begin
      @(posedge clock); #1;
      if (dec_reset === 1'b1) begin
        dph = 0;
        h_strip = 4'd0;
      end else begin
        case (dph)
          0: if (triad === 1'b1) dph = 1;
          1: begin db1 = triad; dph = 2; end
          2: begin didx = {db1, triad}; dph = 3; end
          3: begin
            case (dmode)
              M_IDEAL: dhl = dp + 1;
              M_SHORT: dhl = 3;
              M_WRONG: dhl = 1;
              M_LONG:  dhl = dp + 2;
              default: dhl = 0;
            endcase
            if (dhl == 0) dph = 0;
            else begin
              dwrong = didx + 2'd1;
              h_strip = (dmode == M_WRONG) ? (4'b0001 << dwrong) : (4'b0001 << didx);
              dhc = 1;
              dph = 4;
            end
          end
          default: begin
            if (dhc == dhl) begin
              h_strip = 4'd0;
              dph = 0;
            end else dhc++;
          end
        endcase
      end
    end
  end

  // Monitor: checks triad bit patterns and per-run results against the scoreboard.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (busy === 1'b1) bsy_cnt++;
      if (busy === 1'b1 && dec_reset === 1'b1) dr_cnt++;
      case (tph)
        0: if (triad === 1'b1) tph = 1;
        1: begin tb1 = triad; tph = 2; end
        default: begin
          tph = 0;
          if (tq.size() == 0) begin
            total++; bad++;
            $display("FAIL triad_extra: got bits %b%b with none expected", tb1, triad);
          end else begin
            te = tq.pop_front();
            check("triad_bits", {30'd0, tb1, triad}, te);
          end
        end
      endcase
      if (done === 1'b1) begin
        done_pulses++;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got done pulse with no run pending");
        end else begin
          er = sb.pop_front();
          check("pass_cnt", pass_cnt, er.e_pass);
          check("fail_cnt", fail_cnt, er.e_fail);
          check("skip_cnt", skip_cnt, er.e_skip);
          check("busy_cycles", bsy_cnt, er.e_busy);
          check("dec_reset_cycles", dr_cnt, 2);
        end
        bsy_cnt = 0;
        dr_cnt = 0;
      end
    end
  end

  task automatic start_run(input int num, input int p, input int mode, input int ep,
                           input int ef, input int es, input int eb, input int ntri,
                           input bit push_sb);
    exp_t r;
    num_triads = 8'(num);
    persist = 4'(p);
    dmode = mode;
    dp = p;
    r.e_pass = ep; r.e_fail = ef; r.e_skip = es; r.e_busy = eb;
    if (push_sb) sb.push_back(r);
    for (int k = 0; k < ntri; k++) tq.push_back(k % 4);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("persist_o", persist_o, p);
  endtask

  task automatic wait_done(input int limit, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check({name, "_seen"}, seen, 1);
    @(posedge clock); #1;
    check({name, "_pulse_len"}, done, 0);
    check({name, "_idle"}, busy, 0);
    @(negedge clock);
  endtask

  int  pulses_before;
  bit  hs_seen;

  initial begin
    reset = 1'b1; start = 1'b0; num_triads = 8'd0; persist = 4'd0; triad_skip = 1'b0;
    rows[0] = '{4, 4,  M_IDEAL,  4, 0, 63};
    rows[1] = '{4, 4,  M_SHORT,  0, 4, 55};
    rows[2] = '{2, 1,  M_SILENT, 0, 2, 31};
    rows[3] = '{0, 3,  M_IDEAL,  0, 0, 3};
    rows[4] = '{3, 0,  M_IDEAL,  3, 0, 24};
    rows[5] = '{3, 2,  M_WRONG,  0, 3, 27};
    rows[6] = '{2, 1,  M_LONG,   0, 2, 21};
    rows[7] = '{5, 15, M_IDEAL,  5, 0, 188};
    rows[8] = '{6, 3,  M_IDEAL,  6, 0, 81};

    repeat (3) @(negedge clock);
    check("rst_dec_reset", dec_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_triad", triad, 0);
    check("rst_done", done, 0);
    check("rst_counters", {pass_cnt, fail_cnt, skip_cnt}, 0);
    check("rst_persist_o", persist_o, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_dec_reset", dec_reset, 0);

    for (int r = 0; r < 9; r++) begin
      start_run(rows[r].num, rows[r].p, rows[r].mode, rows[r].e_pass, rows[r].e_fail,
                0, rows[r].e_busy, rows[r].num, 1'b1);
      wait_done(3000, "row_done");
    end

    // Long run with triad_skip held high; a mid-run start must be ignored.
    start_run(30, 4, M_IDEAL, 30, 0, 255, 453, 30, 1'b1);
    triad_skip = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (c == 100) begin num_triads = 8'd1; start = 1'b1; end
      else start = 1'b0;
      @(negedge clock);
    end
    triad_skip = 1'b0;
    start = 1'b0;
    wait_done(3000, "skip_run");

    // Reset during the first HOLD aborts the run without a done pulse.
    start_run(4, 4, M_IDEAL, 0, 0, 0, 0, 1, 1'b0);
    triad_skip = 1'b1;
    hs_seen = 1'b0;
    for (int i = 0; i < 200 && !hs_seen; i++) begin
      @(negedge clock);
      if (h_strip != 4'd0) hs_seen = 1'b1;
    end
    check("abort_reach_hold", hs_seen, 1);
    repeat (2) @(negedge clock);
    pulses_before = done_pulses;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    triad_skip = 1'b0;
    bsy_cnt = 0;
    dr_cnt = 0;
    check("abort_triad", triad, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_counters", {pass_cnt, fail_cnt, skip_cnt}, 0);
    check("abort_persist_o", persist_o, 0);
    repeat (20) @(negedge clock);
    check("abort_no_done", done_pulses, pulses_before);
    check("abort_stay_idle", busy, 0);

    start_run(4, 4, M_IDEAL, 4, 0, 0, 63, 4, 1'b1);
    wait_done(3000, "rerun");

    repeat (3) @(negedge clock);
    check("done_pulses", done_pulses, 11);
    check("sb_left", sb.size(), 0);
    check("tq_left", tq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
